// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative read-only cache with true-LRU replacement.
// Ports: clk/rst (async, active-low); start/address/flush request side;
// ready/hit/data response; mem_rd/mem_addr/mem_ack/mem_rdata word-serial fill;
// hit_count/access_count saturating statistics.
module assoc_cache #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int WAYS        = 2,
    parameter int SETS        = 1024,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_W       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] address,
    input  logic              flush,
    output logic              ready,
    output logic              hit,
    output logic [DATA_W-1:0] data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  access_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int OB = (OFF_W > 0) ? OFF_W : 1;
    localparam int IB = (IDX_W > 0) ? IDX_W : 1;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WB-1:0]     r_way;
    logic [OB-1:0]     r_beat;
    logic [DATA_W-1:0] r_word;
    logic              r_ready;
    logic              r_hit;
    logic [DATA_W-1:0] r_data;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [CNT_W-1:0]  r_hitc;
    logic [CNT_W-1:0]  r_accc;
    logic [SETS-1:0]   r_valid [WAYS];
    logic [WB-1:0]     r_age   [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [DATA_W-1:0] r_line  [WAYS][SETS][BLOCK_WORDS];

    logic [IB-1:0]     w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [OB-1:0]     w_off;
    logic              w_last;
    logic              w_hit;
    logic [WB-1:0]     w_hway;
    logic              w_inv;
    logic [WB-1:0]     w_ifree;
    logic [WB-1:0]     w_lru;
    logic [WB-1:0]     w_vict;
    logic              w_touch;
    logic [WB-1:0]     w_acc;
    logic [WB-1:0]     w_acc_age;

    assign w_idx  = IB'(r_addr >> OFF_W);
    assign w_tag  = TAG_W'(r_addr >> (OFF_W + IDX_W));
    assign w_off  = OB'(r_addr & OFF_MASK);
    assign w_last = (r_beat == OB'(BLOCK_WORDS - 1));

    // Tag match across the set; invalid ways scanned high-to-low so the lowest wins.
    always_comb begin
        w_hit   = 1'b0;
        w_hway  = '0;
        w_inv   = 1'b0;
        w_ifree = '0;
        w_lru   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit  = 1'b1;
                w_hway = WB'(w);
            end
            if (r_age[w_idx][w] == WB'(WAYS - 1)) w_lru = WB'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_inv   = 1'b1;
                w_ifree = WB'(w);
            end
        end
    end

    assign w_vict    = w_inv ? w_ifree : w_lru;
    // A way is "touched" on a lookup hit or when its fill completes.
    assign w_touch   = (r_state == LOOKUP && w_hit) || (r_state == FILL && mem_ack && w_last);
    assign w_acc     = (r_state == LOOKUP) ? w_hway : r_way;
    assign w_acc_age = r_age[w_idx][w_acc];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_way      <= '0;
            r_beat     <= '0;
            r_word     <= '0;
            r_ready    <= 1'b0;
            r_hit      <= 1'b0;
            r_data     <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_hitc     <= '0;
            r_accc     <= '0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= WB'(w);
        end else begin
            r_ready <= 1'b0;
            // True LRU: ways younger than the accessed one age by one, accessed way becomes 0.
            if (w_touch)
                for (int w = 0; w < WAYS; w++)
                    if (WB'(w) == w_acc) r_age[w_idx][w] <= '0;
                    else if (r_age[w_idx][w] < w_acc_age) r_age[w_idx][w] <= r_age[w_idx][w] + WB'(1);
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                    end else if (start) begin
                        r_addr  <= address;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_ready <= 1'b1;
                        r_hit   <= 1'b1;
                        r_data  <= r_line[w_hway][w_idx][w_off];
                        r_state <= RESPOND;
                    end else begin
                        r_way      <= w_vict;
                        r_beat     <= '0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_addr & ~OFF_MASK;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        // Requested word is kept aside so data stays stable until ready.
                        if (r_beat == w_off) r_word <= mem_rdata;
                        if (w_last) begin
                            r_mem_rd            <= 1'b0;
                            r_valid[r_way][w_idx] <= 1'b1;
                            r_ready             <= 1'b1;
                            r_hit               <= 1'b0;
                            r_data              <= (r_beat == w_off) ? mem_rdata : r_word;
                            r_state             <= RESPOND;
                        end else begin
                            r_beat     <= r_beat + OB'(1);
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end
                    end
                end
                RESPOND: begin
                    if (~&r_accc) r_accc <= r_accc + CNT_W'(1);
                    if (r_hit && ~&r_hitc) r_hitc <= r_hitc + CNT_W'(1);
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Line storage carries no reset; validity alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (rst && r_state == FILL && mem_ack) begin
            r_line[r_way][w_idx][r_beat] <= mem_rdata;
            if (w_last) r_tag[r_way][w_idx] <= w_tag;
        end
    end

    assign ready        = r_ready;
    assign hit          = r_hit;
    assign data         = r_data;
    assign mem_rd       = r_mem_rd;
    assign mem_addr     = r_mem_addr;
    assign hit_count    = r_hitc;
    assign access_count = r_accc;
endmodule
